// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU issue/write-back sequencer with 8x16 register file
// Optional build macro SEQ_R0_ZERO_EN: r0 reads as zero and ignores writes.

`ifndef OP_ADD
`define OP_ADD   4'h0
`define OP_SUB   4'h1
`define OP_AND   4'h2
`define OP_OR    4'h3
`define OP_XOR   4'h4
`define OP_LOADI 4'h5
`endif

module alu_sequencer (
    input  logic        ck,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_l,
    output logic [15:0] alu_r,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_o,
    output logic        done,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] rf [8];
    logic [2:0]  rd_q;

    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [8:0]  imm9;
    logic        op_legal;
    logic        op_loadi;

    assign opcode = instr[15:12];
    assign rd     = instr[11:9];
    assign rs1    = instr[8:6];
    assign rs2    = instr[5:3];
    assign imm9   = instr[8:0];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            `OP_ADD, `OP_SUB, `OP_AND, `OP_OR, `OP_XOR, `OP_LOADI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    assign op_loadi = (opcode == `OP_LOADI);

    function automatic logic [15:0] rf_read(input logic [2:0] addr);
`ifdef SEQ_R0_ZERO_EN
        rf_read = (addr == 3'd0) ? 16'h0000 : rf[addr];
`else
        rf_read = rf[addr];
`endif
    endfunction

    assign dbg_data = rf_read(dbg_addr);

    always_ff @(posedge ck) begin
        if (res) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            alu_l    <= 16'h0000;
            alu_r    <= 16'h0000;
            alu_op   <= `OP_LOADI;
            done     <= 1'b0;
            illegal  <= 1'b0;
            rd_q     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 16'h0000;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op_legal) begin
                            alu_l    <= rf_read(rs1);
                            alu_r    <= op_loadi ? {7'b0, imm9} : rf_read(rs2);
                            alu_op   <= opcode;
                            rd_q     <= rd;
                            in_ready <= 1'b0;
                            state    <= S_ISSUE;
                        end else begin
                            illegal  <= 1'b1;
                        end
                    end
                end
                // ALU registers the held operands at the end of this cycle.
                S_ISSUE: begin
                    state <= S_WB;
                end
                S_WB: begin
`ifdef SEQ_R0_ZERO_EN
                    if (rd_q != 3'd0) begin
                        rf[rd_q] <= alu_o;
                    end
`else
                    rf[rd_q] <= alu_o;
`endif
                    done     <= 1'b1;
                    alu_op   <= `OP_LOADI;
                    alu_l    <= 16'h0000;
                    alu_r    <= 16'h0000;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a registered ALU model
// Honours SEQ_R0_ZERO_EN when the design is built with it.

`ifndef OP_ADD
`define OP_ADD   4'h0
`define OP_SUB   4'h1
`define OP_AND   4'h2
`define OP_OR    4'h3
`define OP_XOR   4'h4
`define OP_LOADI 4'h5
`endif

module tb_alu_sequencer;

    logic        ck = 1'b0;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_l;
    logic [15:0] alu_r;
    logic [3:0]  alu_op;
    logic [15:0] alu_o;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_sequencer dut (
        .ck       (ck),
        .res      (res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .alu_l    (alu_l),
        .alu_r    (alu_r),
        .alu_op   (alu_op),
        .alu_o    (alu_o),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 ck = ~ck;

    // Registered ALU: result appears the cycle after operands are presented.
    always @(posedge ck) begin
        case (alu_op)
            `OP_ADD:   alu_o <= alu_l + alu_r;
            `OP_SUB:   alu_o <= alu_l - alu_r;
            `OP_AND:   alu_o <= alu_l & alu_r;
            `OP_OR:    alu_o <= alu_l | alu_r;
            `OP_XOR:   alu_o <= alu_l ^ alu_r;
            `OP_LOADI: alu_o <= alu_r;
            default:   alu_o <= 16'hDEAD;
        endcase
    end

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        bit          ill;
        logic [2:0]  rd;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   exp_done_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] rd, input logic [8:0] imm);
        return {`OP_LOADI, rd, imm};
    endfunction

    // Monitor: pops an expectation whenever the DUT signals completion.
    always @(negedge ck) begin
        if (!res && (done || illegal)) begin
            exp_t e;
            if (done) n_done++;
            chk("done_and_illegal_exclusive", {31'b0, done & illegal}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_output", {30'b0, done, illegal}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("out_kind_illegal", {31'b0, illegal}, {31'b0, e.ill});
                chk("out_cycle", cyc, e.cyc);
                if (done && !e.ill) begin
                    dbg_addr = e.rd;
                    #1;
                    chk($sformatf("wb_r%0d", e.rd), {16'b0, dbg_data}, {16'b0, e.val});
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit hold, output int acc);
        int n = 0;
        @(negedge ck);
        instr    = w;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge ck);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge ck);
            #1;
            acc = cyc;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic exp_wb(input logic [2:0] rd, input logic [15:0] val, input int acc);
        exp_t e;
        e.ill = 1'b0; e.rd = rd; e.val = val; e.cyc = acc + 2;
        sbq.push_back(e);
        exp_done_total++;
    endtask

    task automatic exp_ill(input int acc);
        exp_t e;
        e.ill = 1'b1; e.rd = 3'd0; e.val = 16'h0; e.cyc = acc;
        sbq.push_back(e);
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [15:0] v);
        @(negedge ck);
        #2;
        dbg_addr = a;
        #1;
        chk(name, {16'b0, dbg_data}, {16'b0, v});
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge ck);
            n++;
        end
        chk("queue_drain", sbq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, ai, an;
        res      = 1'b1;
        in_valid = 1'b0;
        instr    = 16'h0000;
        dbg_addr = 3'd0;
        repeat (2) @(posedge ck);
        #1;
        res = 1'b0;
        @(negedge ck);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_alu_op", {28'b0, alu_op}, {28'b0, `OP_LOADI});
        chk("rst_alu_l", {16'b0, alu_l}, 32'd0);
        chk("rst_alu_r", {16'b0, alu_r}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        check_reg("rst_r3", 3'd3, 16'h0000);

        // LOADI/LOADI held back-to-back, then ADD
        send(enc_i(3'd1, 9'd5), 1'b1, a1); exp_wb(3'd1, 16'd5, a1);
        send(enc_i(3'd2, 9'd7), 1'b1, a2); exp_wb(3'd2, 16'd7, a2);
        send(enc(`OP_ADD, 3'd3, 3'd1, 3'd2), 1'b0, a3); exp_wb(3'd3, 16'd12, a3);
        chk("accept_spacing_1", a2 - a1, 32'd3);
        chk("accept_spacing_2", a3 - a2, 32'd3);
        drain();
        chk("done_count_first", n_done, 32'd3);
        check_reg("add_r3", 3'd3, 16'd12);

        // Wrap-around SUB, logic ops, rd == rs
        send(enc_i(3'd1, 9'd3), 1'b0, a1); exp_wb(3'd1, 16'h0003, a1);
        send(enc_i(3'd2, 9'd5), 1'b0, a1); exp_wb(3'd2, 16'h0005, a1);
        send(enc(`OP_SUB, 3'd4, 3'd1, 3'd2), 1'b0, a1); exp_wb(3'd4, 16'hFFFE, a1);
        send(enc(`OP_AND, 3'd5, 3'd1, 3'd2), 1'b0, a1); exp_wb(3'd5, 16'h0001, a1);
        send(enc(`OP_OR,  3'd6, 3'd1, 3'd2), 1'b0, a1); exp_wb(3'd6, 16'h0007, a1);
        send(enc(`OP_XOR, 3'd7, 3'd1, 3'd2), 1'b0, a1); exp_wb(3'd7, 16'h0006, a1);
        send(enc(`OP_ADD, 3'd1, 3'd1, 3'd1), 1'b0, a1); exp_wb(3'd1, 16'h0006, a1);
        drain();
        check_reg("sub_wrap_r4", 3'd4, 16'hFFFE);

        // Illegal opcode after LOADI r5,9; next word accepted the following cycle
        send(enc_i(3'd5, 9'd9), 1'b0, a1); exp_wb(3'd5, 16'd9, a1);
        send(16'hF000 | {4'h0, 3'd5, 9'd0}, 1'b0, ai); exp_ill(ai);
        send(enc_i(3'd7, 9'd1), 1'b0, an); exp_wb(3'd7, 16'd1, an);
        chk("accept_after_illegal", an - ai, 32'd1);
        drain();
        check_reg("illegal_r5_kept", 3'd5, 16'd9);

        // Changing instr while busy: only the accepted ADD executes
        send(enc(`OP_ADD, 3'd3, 3'd1, 3'd2), 1'b1, a1); exp_wb(3'd3, 16'd11, a1);
        @(negedge ck);
        instr = enc_i(3'd1, 9'h0FF);
        chk("issue_in_ready", {31'b0, in_ready}, 32'd0);
        chk("issue_alu_l", {16'b0, alu_l}, 32'd6);
        chk("issue_alu_r", {16'b0, alu_r}, 32'd5);
        chk("issue_alu_op", {28'b0, alu_op}, {28'b0, `OP_ADD});
        @(negedge ck);
        instr = enc_i(3'd3, 9'h1AA);
        @(negedge ck);
        in_valid = 1'b0;
        drain();
        check_reg("busy_r1_kept", 3'd1, 16'd6);
        check_reg("busy_r3", 3'd3, 16'd11);

        // Reset during WB aborts the write-back
        send(enc_i(3'd6, 9'h1FF), 1'b0, a1);
        @(posedge ck);
        #1;
        res = 1'b1;
        @(posedge ck);
        #1;
        res = 1'b0;
        @(negedge ck);
        chk("abort_alu_op", {28'b0, alu_op}, {28'b0, `OP_LOADI});
        chk("abort_alu_l", {16'b0, alu_l}, 32'd0);
        chk("abort_alu_r", {16'b0, alu_r}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        check_reg("abort_r6", 3'd6, 16'h0000);
        check_reg("abort_r1_cleared", 3'd1, 16'h0000);

        // imm9 zero extension and r0 behaviour
        send(enc_i(3'd6, 9'h1FF), 1'b0, a1); exp_wb(3'd6, 16'h01FF, a1);
`ifdef SEQ_R0_ZERO_EN
        send(enc_i(3'd0, 9'h055), 1'b0, a1); exp_wb(3'd0, 16'h0000, a1);
        drain();
        check_reg("r0_zero", 3'd0, 16'h0000);
`else
        send(enc_i(3'd0, 9'h055), 1'b0, a1); exp_wb(3'd0, 16'h0055, a1);
        drain();
        check_reg("r0_plain", 3'd0, 16'h0055);
`endif
        repeat (4) @(negedge ck);
        chk("done_total", n_done, exp_done_total);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
